// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: add/sub, bitwise logic and shift units feed a result
// mux; result, carry and zero are captured in one register stage.

module alu_addsub (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_sub,
  output logic [7:0] o_res,
  output logic       o_carry
);
  logic [8:0] w_sum;

  // Bit 8 of the 9-bit difference is the borrow, so one flag serves both ops.
  assign w_sum   = i_sub ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});
  assign o_res   = w_sum[7:0];
  assign o_carry = w_sum[8];
endmodule

module alu_logic (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [1:0] i_sel,
  output logic [7:0] o_res
);
  always_comb begin
    o_res = 8'h00;
    case (i_sel)
      2'b00: o_res = i_a & i_b;
      2'b01: o_res = i_a | i_b;
      2'b10: o_res = i_a ^ i_b;
      2'b11: o_res = ~i_a;
    endcase
  end
endmodule

module alu_shift (
  input  logic [7:0] i_a,
  input  logic       i_right,
  output logic [7:0] o_res,
  output logic       o_carry
);
  assign o_res   = i_right ? {1'b0, i_a[7:1]} : {i_a[6:0], 1'b0};
  assign o_carry = i_right ? i_a[0] : i_a[7];
endmodule

module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] opcode,
  output logic [7:0] out,
  output logic       carry,
  output logic       zero
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [7:0] w_as_res, w_lg_res, w_sh_res, w_res;
  logic       w_as_c, w_sh_c, w_c;
  logic [7:0] r_out;
  logic       r_carry, r_zero;

  alu_addsub u_addsub (
    .i_a(a), .i_b(b), .i_sub(opcode[0]), .o_res(w_as_res), .o_carry(w_as_c)
  );

  // {opcode[2], opcode[0]} maps AND/OR/XOR/NOT onto 00/01/10/11.
  alu_logic u_logic (
    .i_a(a), .i_b(b), .i_sel({opcode[2], opcode[0]}), .o_res(w_lg_res)
  );

  alu_shift u_shift (
    .i_a(a), .i_right(opcode[0]), .o_res(w_sh_res), .o_carry(w_sh_c)
  );

  always_comb begin
    w_res = 8'h00;
    w_c   = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin w_res = w_as_res; w_c = w_as_c; end
      OP_AND, OP_OR,
      OP_XOR, OP_NOT: begin w_res = w_lg_res; w_c = 1'b0;   end
      OP_SHL, OP_SHR: begin w_res = w_sh_res; w_c = w_sh_c; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= 8'h00;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_out   <= w_res;
      r_carry <= w_c;
      r_zero  <= (w_res == 8'h00);
    end
  end

  assign out   = r_out;
  assign carry = r_carry;
  assign zero  = r_zero;
endmodule

// File: tb/tb_alu_8bit.sv
// Bench for alu_8bit: directed literal vectors plus a per-cycle compare
// against an arithmetic reference model, including a mid-stream reset.

module tb_alu_8bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] opcode;
  logic [7:0] out;
  logic       carry, zero;

  int checks   = 0;
  int failures = 0;

  alu_8bit dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .opcode(opcode),
    .out(out), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {out, carry, zero}.
  function automatic logic [9:0] model(input logic [7:0] ia, input logic [7:0] ib,
                                       input logic [2:0] op);
    int x, y, r, c;
    logic [7:0] rv;
    x = ia; y = ib; c = 0; r = 0;
    case (op)
      3'd0: begin r = x + y; c = (r > 255) ? 1 : 0; r = r % 256; end
      3'd1: begin c = (x < y) ? 1 : 0; r = (x - y + 256) % 256; end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = 255 - x;
      3'd6: begin r = (x * 2) % 256; c = (x >= 128) ? 1 : 0; end
      3'd7: begin r = x / 2; c = x % 2; end
    endcase
    rv = r[7:0];
    return {rv, c[0], (r == 0)};
  endfunction

  logic [9:0] exp_v;
  logic       exp_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) exp_v = {8'h00, 1'b0, 1'b1};
    else        exp_v = model(a, b, opcode);
    exp_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
               name, act[9:2], act[1], act[0], req[9:2], req[1], req[0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) chk("model", {out, carry, zero}, exp_v);
  end

  // Called just after a negedge: drive, let one posedge pass, check literal.
  task automatic step(input string name, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [2:0] op, input logic [9:0] req);
    a = ia; b = ib; opcode = op;
    @(negedge clk);
    chk(name, {out, carry, zero}, req);
  endtask

  task automatic sweep(input string name, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [63:0] outs, input logic [7:0] cs, input logic [7:0] zs);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = i[2:0];
      step($sformatf("%s_op%0d", name, i), ia, ib, op, {outs[i*8 +: 8], cs[i], zs[i]});
    end
  endtask

  initial begin
    rst_n = 1'b0; a = 8'h12; b = 8'h34; opcode = 3'd0;
    @(negedge clk);
    chk("rst1", {out, carry, zero}, {8'h00, 1'b0, 1'b1});
    @(negedge clk);
    chk("rst2", {out, carry, zero}, {8'h00, 1'b0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {out, carry, zero}, {8'h46, 1'b0, 1'b0});

    // op7 .. op0 packed from the MSB down.
    sweep("z00", 8'h00, 8'h00, {8'h00,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00},
          8'b0000_0000, 8'b1101_1111);
    sweep("zFF", 8'hFF, 8'hFF, {8'h7F,8'hFE,8'h00,8'h00,8'hFF,8'hFF,8'h00,8'hFE},
          8'b1100_0001, 8'b0011_0010);
    sweep("zAA", 8'hAA, 8'h55, {8'h55,8'h54,8'h55,8'hFF,8'hFF,8'h00,8'h55,8'hFF},
          8'b0100_0000, 8'b0000_0100);

    step("borrow", 8'h05, 8'h0A, 3'd1, {8'hFB, 1'b1, 1'b0});
    step("wrap",   8'h80, 8'h80, 3'd0, {8'h00, 1'b1, 1'b1});
    step("shl80",  8'h80, 8'h00, 3'd6, {8'h00, 1'b1, 1'b1});
    step("shr01",  8'h01, 8'hFF, 3'd7, {8'h00, 1'b1, 1'b1});

    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
      rst_n = (i == 500 || i == 501) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (i == 500 || i == 501)
        chk("rand_rst", {out, carry, zero}, {8'h00, 1'b0, 1'b1});
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_8bit.md
# alu_8bit

Registered 8-bit arithmetic/logic unit: two 8-bit operands and a 3-bit opcode select one of eight operations; the result and two status flags are captured on the rising clock edge. It is a leaf datapath block for small controllers and test harnesses that need a single-cycle ALU with a stable registered output. Internally it is split into an adder/subtractor, a bitwise logic unit and a shifter, followed by a result multiplexer and output registers.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a  input  8  operand A, unsigned.
- b  input  8  operand B, unsigned; ignored by NOT, SHL and SHR.
- opcode  input  3  operation select.
- out  output  8  registered result.
- carry  output  1  registered carry/borrow/shift-out flag.
- zero  output  1  registered flag, 1 when the computed result is 0x00.

## Operation
- 000 ADD: out = (a + b) mod 256; carry = bit 8 of the 9-bit sum.
- 001 SUB: out = (a - b) mod 256; carry = 1 when a < b (borrow), else 0.
- 010 AND: out = a & b; carry = 0.
- 011 OR: out = a | b; carry = 0.
- 100 XOR: out = a ^ b; carry = 0.
- 101 NOT: out = ~a; carry = 0.
- 110 SHL: out = {a[6:0], 1'b0}; carry = a[7].
- 111 SHR: logical, out = {1'b0, a[7:1]}; carry = a[0].
- zero = (next out == 0x00) for every opcode, computed from the same result being registered.
- All operands are treated as unsigned; no overflow flag, no signed interpretation.
- No X propagation permitted beyond the inputs: every opcode value is defined, so there is no default/illegal case.

## Timing
- Combinational compute path from a, b, opcode to the output register D inputs; one register stage.
- Latency: one cycle. Inputs sampled at rising edge N appear on out/carry/zero after edge N and hold until edge N+1.
- No handshake; a new operation may be issued every cycle (throughput one per cycle).
- Reset: on any rising edge with rst_n = 0, out = 0x00, carry = 0, zero = 1. Reset overrides any operation in the same cycle; inputs during reset are discarded.
- Reset deasserted: first edge with rst_n = 1 captures the then-present inputs normally.
- Outputs change only on clock edges; input changes between edges do not affect outputs.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with a = 0x12, b = 0x34, opcode = 000 -> out = 0x00, carry = 0, zero = 1; release, next edge -> out = 0x46, carry = 0, zero = 0.
- a = 0x00, b = 0x00, sweep opcode 0..7 one per cycle -> out 0x00,0x00,0x00,0x00,0x00,0xFF,0x00,0x00; carry all 0; zero = 1 except NOT.
- a = 0xFF, b = 0xFF, sweep 0..7 -> out 0xFE,0x00,0xFF,0xFF,0x00,0x00,0xFE,0x7F; carry 1,0,0,0,0,0,1,1; zero set for SUB, XOR, NOT.
- a = 0xAA, b = 0x55, sweep 0..7 -> out 0xFF,0x55,0x00,0xFF,0xFF,0x55,0x54,0x55; carry 0,0,0,0,0,0,1,0; zero set only for AND.
- Borrow/wrap: a = 0x05, b = 0x0A, SUB -> out = 0xFB, carry = 1; a = 0x80, b = 0x80, ADD -> out = 0x00, carry = 1, zero = 1.
- Latency/throughput: random a, b, opcode changed every cycle for 1000 cycles, reset pulsed low mid-stream -> each output equals the reference model of the previous cycle's inputs; cycle after a reset edge shows 0x00/0/1.
